i2s_lock_ctrl: RTL and testbench
================================

Name: i2s_lock_ctrl

Overview:
Frame-lock and mute sequencer for the I2S-to-PCM1704 datapath. Runs on BCK and checks LRCK framing: the slot length per LRCK half-period and LRCK activity. Acquires lock only after a run of consecutive good frames. Drives MUTE, which gates DATAOUTL/DATAOUTR to zero in the top level, and the status LED, so the DACs never receive a misaligned word.

Parameters:
SLOT_BITS, 32, required BCK cycles per LRCK half-period (64fs framing)
LOCK_FRAMES, 4, consecutive good frames needed to lock
HOLDOFF_FRAMES, 2, frames ignored after an error before re-acquisition starts
WDOG_CYCLES, 256, BCK cycles without an LRCK edge before LRCK is declared stalled
CNT_W, 9, width of the half-period counter; must satisfy 2^CNT_W > WDOG_CYCLES

Ports:
BCK  in  1  bit clock, the only clock; all logic on posedge
RST  in  1  synchronous reset, active-high
LRCK  in  1  I2S word clock; 0 = left slot; falling edge = frame start
LOCK  out  1  framing locked
MUTE  out  1  1 = top level forces serial data outputs to 0
FRAME_ERR  out  1  one-cycle pulse per detected framing error
ERR_CNT  out  8  saturating error count
LED1  out  1  active-low lock indicator (0 = LED on = locked)

Behaviour:
- Interface: one clock, BCK. RST is synchronous and active-high. All outputs are registered.
- Reset values: LOCK=0, MUTE=1, FRAME_ERR=0, ERR_CNT=0, LED1=1, state=UNLOCKED, internal counters=0. lrck_q loads the current LRCK during reset.
- RST asserted mid-operation: every output takes its reset value on the next posedge, regardless of state.
- Edge detect: lrck_q <= LRCK each cycle. A cycle with LRCK != lrck_q is an edge cycle. 1->0 is a frame edge; 0->1 is a mid edge.
- Half-period counter cnt: cleared to 0 on an edge cycle, otherwise increments. Measured length at an edge is cnt+1, so a 32-BCK half-period measures exactly 32. cnt saturates at WDOG_CYCLES.
- Half-period good: measured length == SLOT_BITS. Frame good: both halves since the previous frame edge were good. The frame is judged on the frame-edge cycle.
- Watchdog: cnt reaching WDOG_CYCLES-1 without an edge is a stall. If an edge and the watchdog fire in the same cycle, the edge wins and no stall is flagged.
- Error event: bad frame judged while in LOCKED or HOLDOFF, a bad half-period at a mid edge while in LOCKED, or a stall in any state except UNLOCKED.
- On an error event: FRAME_ERR=1 for exactly one cycle, ERR_CNT += 1 saturating at 255, MUTE=1 and LOCK=0 on the next posedge (latency 1). Mute on error is immediate, not frame-aligned.
- State UNLOCKED: MUTE=1. First frame edge -> ACQUIRE with good_cnt=0. That first frame is not judged.
- State ACQUIRE: MUTE=1. Good frame: good_cnt+1. Bad frame: good_cnt=0, stay in ACQUIRE, no FRAME_ERR. When good_cnt reaches LOCK_FRAMES -> LOCKED, LOCK=1, MUTE=0. This transition happens on the frame-edge cycle, so unmute is frame-aligned.
- State LOCKED: stays while frames are good. Error -> HOLDOFF with hold_cnt=0. Stall -> UNLOCKED.
- State HOLDOFF: MUTE=1. Each frame edge increments hold_cnt, whatever the frame quality. At HOLDOFF_FRAMES -> ACQUIRE with good_cnt=0. Stall -> UNLOCKED.
- LED1 = ~LOCK, registered.
- Sizing: good_cnt and hold_cnt are 4 bits each. LOCK_FRAMES and HOLDOFF_FRAMES are limited to 15.

Decomposition:
- Package i2s_ctrl_pkg holds:
  - the state encoding: UNLOCKED=2'd0, ACQUIRE=2'd1, LOCKED=2'd2, HOLDOFF=2'd3
  - default SLOT_BITS, LOCK_FRAMES, HOLDOFF_FRAMES and WDOG_CYCLES constants
  - ERR_CNT width
- Sub-module lrck_period_meter contains lrck_q, the edge detect, cnt and the watchdog. Its outputs:
  - frame_edge
  - mid_edge
  - half_ok
  - frame_ok
  - stall
- i2s_lock_ctrl contains the FSM, the lock/holdoff counters, the error counter and the output registers.

Test Plan:
1. RST 2 cycles, then a clean stream of 32 BCK per half -> LOCK=1 and MUTE=0 one cycle after the 5th frame edge (1 unjudged + 4 good frames); LED1=0; FRAME_ERR never pulses.
2. While locked, one left half of 31 BCK -> FRAME_ERR one-cycle pulse after the mid edge, MUTE=1 next cycle, ERR_CNT=1; HOLDOFF for 2 frame edges, then 4 good frames -> LOCK=1 again.
3. While locked, LRCK held at 0 for 300 cycles -> stall at cnt=255, FRAME_ERR pulse, ERR_CNT+1, state UNLOCKED, MUTE=1. Resume a clean stream -> relock after 1+4 frame edges.
4. Repeated injection of 260 bad frames alternating with relock -> ERR_CNT stops at 255 and does not wrap.
5. RST asserted for 1 cycle while LOCKED mid-frame -> next posedge LOCK=0, MUTE=1, ERR_CNT=0, LED1=1; relock follows the scenario 1 timing.
6. Stream with 48 BCK per half -> remains in ACQUIRE, LOCK=0, MUTE=1 indefinitely, no FRAME_ERR pulses.

Source files
------------

// File: rtl/i2s_ctrl_pkg.sv
// Purpose: shared constants for the I2S frame-lock controller (state codes, default timing, counter widths).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_ctrl_pkg;

   // Lock FSM state encoding (kept as plain 2-bit constants for legacy tools)
   localparam logic [1:0] UNLOCKED = 2'd0;
   localparam logic [1:0] ACQUIRE  = 2'd1;
   localparam logic [1:0] LOCKED   = 2'd2;
   localparam logic [1:0] HOLDOFF  = 2'd3;

   // Default framing parameters: 64fs framing, 32 BCK per LRCK half-period
   localparam int SLOT_BITS_DEF      = 32;
   localparam int LOCK_FRAMES_DEF    = 4;
   localparam int HOLDOFF_FRAMES_DEF = 2;
   localparam int WDOG_CYCLES_DEF    = 256;
   localparam int CNT_W_DEF          = 9;

   // Width of the saturating framing-error counter
   localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/lrck_period_meter.sv
// Purpose: LRCK edge detector, half-period length meter and stall watchdog, clocked by BCK.
// Latency: outputs are combinational on the edge/stall cycle (lrck_q/cnt registered one cycle behind LRCK).
// Backpressure: none; a free-running measurement path with no flow control.
// Ports: BCK/RST (sync, active-high) clock and reset; LRCK word clock in;
//        frame_edge (1->0), mid_edge (0->1), half_ok / frame_ok (valid on the matching edge), stall (watchdog).
module lrck_period_meter
   import i2s_ctrl_pkg::*;
#(
   parameter int SLOT_BITS   = SLOT_BITS_DEF,
   parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic BCK,
   input  logic RST,
   input  logic LRCK,
   output logic frame_edge,
   output logic mid_edge,
   output logic half_ok,
   output logic frame_ok,
   output logic stall
);

   localparam logic [CNT_W-1:0] WDOG_MAX  = CNT_W'(WDOG_CYCLES);
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
   localparam logic [CNT_W:0]   SLOT_LEN  = (CNT_W+1)'(SLOT_BITS);

   logic             lrck_q,  lrck_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             h1_ok_q, h1_ok_d;   // left half since the last frame edge measured good
   logic             edge_c;
   logic [CNT_W:0]   meas_len;

   always_comb begin
      lrck_d     = LRCK;
      edge_c     = (LRCK != lrck_q);
      frame_edge = edge_c & lrck_q;
      mid_edge   = edge_c & ~lrck_q;

      // cnt counts cycles since the last edge, so the closing edge cycle adds one
      meas_len   = {1'b0, cnt_q} + (CNT_W+1)'(1);
      half_ok    = (meas_len == SLOT_LEN);
      frame_ok   = h1_ok_q & half_ok;

      // An edge on the watchdog cycle means LRCK is alive, so it suppresses the stall
      stall      = ~edge_c & (cnt_q == WDOG_LAST);

      if (edge_c) begin
         cnt_d = '0;
      end else if (cnt_q != WDOG_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end

      h1_ok_d = h1_ok_q;
      if (mid_edge) begin
         h1_ok_d = half_ok;
      end else if (frame_edge) begin
         h1_ok_d = 1'b0;
      end
   end

   always_ff @(posedge BCK) begin
      if (RST) begin
         lrck_q  <= LRCK;
         cnt_q   <= '0;
         h1_ok_q <= 1'b0;
      end else begin
         lrck_q  <= lrck_d;
         cnt_q   <= cnt_d;
         h1_ok_q <= h1_ok_d;
      end
   end

endmodule

// File: rtl/i2s_lock_ctrl.sv
// Purpose: frame-lock / mute sequencer for the I2S-to-PCM1704 path; mutes data until LRCK framing is proven good.
// Latency: all outputs registered, 1 BCK after the judging edge or stall cycle.
// Backpressure: none; LRCK is observed, never stalled.
// Ports: BCK/RST (sync, active-high); LRCK in; LOCK, MUTE (1 = force data to 0), FRAME_ERR (1-cycle pulse),
//        ERR_CNT (saturating), LED1 (active-low lock LED).
module i2s_lock_ctrl
   import i2s_ctrl_pkg::*;
#(
   parameter int SLOT_BITS      = SLOT_BITS_DEF,
   parameter int LOCK_FRAMES    = LOCK_FRAMES_DEF,
   parameter int HOLDOFF_FRAMES = HOLDOFF_FRAMES_DEF,
   parameter int WDOG_CYCLES    = WDOG_CYCLES_DEF,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic                 BCK,
   input  logic                 RST,
   input  logic                 LRCK,
   output logic                 LOCK,
   output logic                 MUTE,
   output logic                 FRAME_ERR,
   output logic [ERR_CNT_W-1:0] ERR_CNT,
   output logic                 LED1
);

   localparam logic [3:0]           LOCK_N  = 4'(LOCK_FRAMES);
   localparam logic [3:0]           HOLD_N  = 4'(HOLDOFF_FRAMES);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   logic frame_edge, mid_edge, half_ok, frame_ok, stall;

   lrck_period_meter #(
      .SLOT_BITS   (SLOT_BITS),
      .WDOG_CYCLES (WDOG_CYCLES),
      .CNT_W       (CNT_W)
   ) u_meter (
      .BCK        (BCK),
      .RST        (RST),
      .LRCK       (LRCK),
      .frame_edge (frame_edge),
      .mid_edge   (mid_edge),
      .half_ok    (half_ok),
      .frame_ok   (frame_ok),
      .stall      (stall)
   );

   logic [1:0]           state_q,     state_d;
   logic [3:0]           good_cnt_q,  good_cnt_d;
   logic [3:0]           hold_cnt_q,  hold_cnt_d;
   logic                 lock_q,      lock_d;
   logic                 mute_q,      mute_d;
   logic                 frame_err_q, frame_err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;
   logic                 led1_q,      led1_d;
   logic                 err_ev;

   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      hold_cnt_d = hold_cnt_q;
      err_ev     = 1'b0;

      case (state_q)
         UNLOCKED: begin
            // The frame ending here started before we were watching, so it is not judged
            if (frame_edge) begin
               state_d    = ACQUIRE;
               good_cnt_d = '0;
            end
         end
         ACQUIRE: begin
            if (stall) begin
               err_ev  = 1'b1;
               state_d = UNLOCKED;
            end else if (frame_edge) begin
               if (frame_ok) begin
                  good_cnt_d = good_cnt_q + 4'd1;
                  // Switching on the frame edge makes the unmute frame-aligned
                  if (good_cnt_d == LOCK_N) begin
                     state_d = LOCKED;
                  end
               end else begin
                  good_cnt_d = '0;
               end
            end
         end
         LOCKED: begin
            if (stall) begin
               err_ev  = 1'b1;
               state_d = UNLOCKED;
            end else if ((frame_edge & ~frame_ok) | (mid_edge & ~half_ok)) begin
               err_ev     = 1'b1;
               state_d    = HOLDOFF;
               hold_cnt_d = '0;
            end
         end
         HOLDOFF: begin
            if (stall) begin
               err_ev  = 1'b1;
               state_d = UNLOCKED;
            end else if (frame_edge) begin
               // Bad frames are still counted as errors, but holdoff advances regardless
               err_ev     = ~frame_ok;
               hold_cnt_d = hold_cnt_q + 4'd1;
               if (hold_cnt_d == HOLD_N) begin
                  state_d    = ACQUIRE;
                  good_cnt_d = '0;
               end
            end
         end
         default: begin
            state_d = UNLOCKED;
         end
      endcase

      // Outputs follow the next state so an error mutes on the very next edge
      lock_d      = (state_d == LOCKED);
      mute_d      = ~lock_d;
      led1_d      = ~lock_d;
      frame_err_d = err_ev;
      err_cnt_d   = (err_ev && (err_cnt_q != ERR_MAX)) ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;
   end

   always_ff @(posedge BCK) begin
      if (RST) begin
         state_q     <= UNLOCKED;
         good_cnt_q  <= '0;
         hold_cnt_q  <= '0;
         lock_q      <= 1'b0;
         mute_q      <= 1'b1;
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
         led1_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         good_cnt_q  <= good_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         lock_q      <= lock_d;
         mute_q      <= mute_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
         led1_q      <= led1_d;
      end
   end

   assign LOCK      = lock_q;
   assign MUTE      = mute_q;
   assign FRAME_ERR = frame_err_q;
   assign ERR_CNT   = err_cnt_q;
   assign LED1      = led1_q;

endmodule

// File: tb/tb_i2s_lock_ctrl.sv
// Purpose: directed self-checking bench for i2s_lock_ctrl; expected FRAME_ERR pulse cycles are queued as stimulus is driven.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2s_lock_ctrl;

   logic       BCK  = 1'b0;
   logic       RST  = 1'b1;
   logic       LRCK = 1'b1;
   logic       LOCK, MUTE, FRAME_ERR, LED1;
   logic [7:0] ERR_CNT;

   i2s_lock_ctrl dut (
      .BCK       (BCK),
      .RST       (RST),
      .LRCK      (LRCK),
      .LOCK      (LOCK),
      .MUTE      (MUTE),
      .FRAME_ERR (FRAME_ERR),
      .ERR_CNT   (ERR_CNT),
      .LED1      (LED1)
   );

   always #5 BCK = ~BCK;

   int   cyc = 0;
   always @(posedge BCK) cyc <= cyc + 1;

   int   checks = 0;
   int   passed = 0;
   int   exp_q[$];          // cycles at which a FRAME_ERR pulse is expected
   int   exp_err_raw = 0;   // unsaturated count of expected errors since reset
   int   lock_rise_cyc = -1;
   int   mute_rise_cyc = -1;
   logic lock_prev = 1'b0;
   logic mute_prev = 1'b1;
   logic lrck_prev = 1'b1;  // LRCK value the DUT sampled on the previous posedge
   int   last_fe_cyc = 0;
   int   last_me_cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int exp_cnt();
      return (exp_err_raw > 255) ? 255 : exp_err_raw;
   endfunction

   task automatic push_err(input int c);
      exp_q.push_back(c);
      exp_err_raw++;
   endtask

   // Scoreboard: every FRAME_ERR pulse must match the oldest expected cycle
   always @(negedge BCK) begin
      if (FRAME_ERR === 1'b1) begin
         if (exp_q.size() == 0) check("frame_err_unexpected_cyc", cyc, 32'hFFFF_FFFF);
         else                   check("frame_err_cyc", cyc, exp_q.pop_front());
      end
      if (LOCK === 1'b1 && lock_prev === 1'b0) lock_rise_cyc <= cyc;
      if (MUTE === 1'b1 && mute_prev === 1'b0) mute_rise_cyc <= cyc;
      lock_prev <= LOCK;
      mute_prev <= MUTE;
   end

   // Hold LRCK at v for n BCK cycles; optionally expect an error pulse on the opening edge
   task automatic half(input logic v, input int n, input bit exp_edge_err);
      for (int i = 0; i < n; i++) begin
         LRCK = v;
         @(posedge BCK); #1;
         if (i == 0 && v != lrck_prev) begin
            if (v == 1'b0) last_fe_cyc = cyc;
            else           last_me_cyc = cyc;
            if (exp_edge_err) push_err(cyc);
         end
         lrck_prev = v;
      end
   endtask

   task automatic frame(input int nl, input int nr, input bit el, input bit er);
      half(1'b0, nl, el);
      half(1'b1, nr, er);
   endtask

   task automatic do_reset(input int n, input logic v);
      RST  = 1'b1;
      LRCK = v;
      repeat (n) @(posedge BCK);
      #1;
      RST         = 1'b0;
      lrck_prev   = v;
      exp_err_raw = 0;
   endtask

   initial begin
      // 1: reset, then clean 32/32 stream locks on the 5th frame edge
      do_reset(2, 1'b1);
      check("rst_lock", LOCK, 0);
      check("rst_mute", MUTE, 1);
      check("rst_frame_err", FRAME_ERR, 0);
      check("rst_err_cnt", ERR_CNT, 0);
      check("rst_led1", LED1, 1);
      repeat (4) frame(32, 32, 0, 0);
      check("s1_lock_before_5th", LOCK, 0);
      frame(32, 32, 0, 0);
      check("s1_lock_rise_cyc", lock_rise_cyc, last_fe_cyc);
      check("s1_lock", LOCK, 1);
      check("s1_mute", MUTE, 0);
      check("s1_led1", LED1, 0);
      check("s1_err_cnt", ERR_CNT, 0);

      // 2: 31-BCK left half while locked -> error at the mid edge, holdoff, relock
      half(1'b0, 31, 0);
      half(1'b1, 32, 1);
      check("s2_mute_rise_cyc", mute_rise_cyc, last_me_cyc);
      check("s2_lock", LOCK, 0);
      check("s2_mute", MUTE, 1);
      check("s2_led1", LED1, 1);
      check("s2_err_cnt", ERR_CNT, 1);
      frame(32, 32, 1, 0);     // the damaged frame is judged again in HOLDOFF
      check("s2_err_cnt_holdoff", ERR_CNT, exp_cnt());
      repeat (4) frame(32, 32, 0, 0);
      check("s2_lock_before_relock", LOCK, 0);
      frame(32, 32, 0, 0);
      check("s2_relock_cyc", lock_rise_cyc, last_fe_cyc);
      check("s2_relock", LOCK, 1);

      // 3: LRCK stuck low -> stall 256 cycles after the last edge, unlock, relock
      half(1'b0, 1, 0);
      push_err(last_fe_cyc + 256);
      half(1'b0, 299, 0);
      check("s3_lock", LOCK, 0);
      check("s3_mute", MUTE, 1);
      check("s3_led1", LED1, 1);
      check("s3_err_cnt", ERR_CNT, exp_cnt());
      half(1'b1, 32, 0);
      repeat (4) frame(32, 32, 0, 0);
      check("s3_lock_before_relock", LOCK, 0);
      frame(32, 32, 0, 0);
      check("s3_relock_cyc", lock_rise_cyc, last_fe_cyc);
      check("s3_relock", LOCK, 1);

      // 4: bursts of 1-BCK bad frames (3 errors per round) until ERR_CNT saturates
      for (int r = 0; r < 86; r++) begin
         frame(1, 1, 0, 1);
         frame(1, 1, 1, 0);
         frame(32, 32, 1, 0);
         repeat (4) frame(32, 32, 0, 0);
         check("s4_err_cnt", ERR_CNT, exp_cnt());
         check("s4_relock", LOCK, 1);
      end
      check("s4_err_cnt_sat", ERR_CNT, 255);

      // 5: one-cycle reset mid-frame while locked, then relock with scenario 1 timing
      half(1'b0, 10, 0);
      do_reset(1, 1'b0);
      check("s5_lock", LOCK, 0);
      check("s5_mute", MUTE, 1);
      check("s5_err_cnt", ERR_CNT, 0);
      check("s5_led1", LED1, 1);
      check("s5_frame_err", FRAME_ERR, 0);
      half(1'b0, 22, 0);
      half(1'b1, 32, 0);
      repeat (4) frame(32, 32, 0, 0);
      check("s5_lock_before_relock", LOCK, 0);
      frame(32, 32, 0, 0);
      check("s5_relock_cyc", lock_rise_cyc, last_fe_cyc);
      check("s5_relock", LOCK, 1);

      // 6: 48 BCK per half never locks and never flags an error
      do_reset(2, 1'b1);
      repeat (6) frame(48, 48, 0, 0);
      check("s6_lock", LOCK, 0);
      check("s6_mute", MUTE, 1);
      check("s6_err_cnt", ERR_CNT, 0);
      check("s6_led1", LED1, 1);

      check("sb_pending", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
